// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift engine: shift modes and FSM states.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        ASR = 2'b01,
        LSL = 2'b10,
        ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift step: next register value and the bit that falls out.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             serial_in,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = q[0];
        case (mode)
            LSR: q_next = {serial_in, q[WIDTH-1:1]};
            ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            LSL: begin
                q_next  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            ROR: q_next = {q[0], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift engine with start/busy/done handshake.
// Optional abort input when SEQ_SHIFT_ABORT_EN is defined.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
`ifdef SEQ_SHIFT_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_e           state;
    shift_mode_e      mode_r;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] q_next;
    logic             out_bit;

    assign amt_clamped = (amount > AMT_MAX) ? AMT_MAX : amount;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q        (q),
        .serial_in(serial_in),
        .mode     (mode_r),
        .q_next   (q_next),
        .out_bit  (out_bit)
    );

    // busy/done are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mode_r     <= LSR;
            cnt        <= '0;
            q          <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q          <= load_val;
                        serial_out <= 1'b0;
                        mode_r     <= shift_mode_e'(mode);
                        cnt        <= amt_clamped;
                        if (amt_clamped == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
`ifdef SEQ_SHIFT_ABORT_EN
                    if (abort) begin
                        // partial result is left in q for inspection
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
`else
                    begin
`endif
                        q          <= q_next;
                        serial_out <= out_bit;
                        cnt        <= cnt - AMT_ONE;
                        if (cnt == AMT_ONE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized self-checking bench for seq_shift_unit against a transaction-level model.
module tb_seq_shift_unit;

    localparam int W = 8;
    localparam int AW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  load_val;
    logic [1:0]    mode;
    logic [AW-1:0] amount;
    logic          serial_in;
    logic [W-1:0]  q;
    logic          serial_out;
    logic          busy;
    logic          done;
`ifdef SEQ_SHIFT_ABORT_EN
    logic          abort = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    seq_shift_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .load_val  (load_val),
        .mode      (mode),
        .amount    (amount),
        .serial_in (serial_in),
`ifdef SEQ_SHIFT_ABORT_EN
        .abort     (abort),
`endif
        .q         (q),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operation result from the mode rules, in integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] lv, input logic [1:0] md,
                                         input int n, input logic [8:0] bits);
        int qv;
        int so;
        qv = int'(lv);
        so = 0;
        for (int i = 0; i < n; i++) begin
            case (md)
                2'd0: begin so = qv % 2; qv = qv / 2 + (bits[i] ? 128 : 0); end
                2'd1: begin so = qv % 2; qv = qv / 2 + (qv & 128); end
                2'd2: begin so = qv / 128; qv = (qv * 2) % 256 + (bits[i] ? 1 : 0); end
                default: begin so = qv % 2; qv = qv / 2 + so * 128; end
            endcase
        end
        return {so[0], qv[7:0]};
    endfunction

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic do_op(input logic [7:0] lv, input logic [1:0] md, input logic [AW-1:0] amt,
                         input int fill, input bit glitch, input string tag,
                         output logic [7:0] q_obs, output logic so_obs);
        logic [8:0] bits;
        logic [8:0] exp;
        int n;
        int bc;
        bit got;
        n = (int'(amt) > W) ? W : int'(amt);
        for (int i = 0; i < 9; i++) bits[i] = (fill < 0) ? 1'($urandom) : fill[0];
        exp = model(lv, md, n, bits);
        start = 1'b1; load_val = lv; mode = md; amount = amt; serial_in = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) begin
                    serial_in = (bc < 9) ? bits[bc] : 1'b0;
                    bc++;
                end
                if (glitch && bc == 2 && busy) begin
                    start = 1'b1; load_val = 8'($urandom); mode = 2'($urandom); amount = AW'($urandom);
                end else start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(n));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_q"}, 64'(q), 64'(exp[7:0]));
        chk({tag, "_so"}, 64'(serial_out), 64'(exp[8]));
        q_obs = q;
        so_obs = serial_out;
    endtask

    initial begin
        logic [7:0] qo;
        logic so;
        int dcnt;
        reset_n = 1'b0; start = 1'b0; load_val = '0; mode = '0; amount = '0; serial_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_so", 64'(serial_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(8'h96, 2'd0, 4'd3, 0, 1'b0, "lsr", qo, so);
        chk("lsr_q_const", 64'(qo), 64'h12);
        chk("lsr_so_const", 64'(so), 64'd1);
        @(negedge clk);
        chk("lsr_done_1cyc", 64'(done), 64'd0);

        do_op(8'hA0, 2'd1, 4'd2, -1, 1'b0, "asr", qo, so);
        chk("asr_q_const", 64'(qo), 64'hE8);
        @(negedge clk);
        do_op(8'h81, 2'd2, 4'd1, 1, 1'b0, "lsl", qo, so);
        chk("lsl_q_const", 64'(qo), 64'h03);
        chk("lsl_so_const", 64'(so), 64'd1);
        @(negedge clk);

        do_op(8'h01, 2'd3, 4'd9, -1, 1'b0, "ror", qo, so);
        chk("ror_q_const", 64'(qo), 64'h01);
        @(negedge clk);
        chk("ror_done_1cyc", 64'(done), 64'd0);

        do_op(8'h5A, 2'd1, 4'd0, -1, 1'b0, "amt0", qo, so);
        chk("amt0_q_const", 64'(qo), 64'h5A);
        @(negedge clk);

        // ignored mid-shift start, then back-to-back start in the done cycle
        do_op(8'h96, 2'd2, 4'd5, -1, 1'b1, "glitch", qo, so);
        do_op(8'h0F, 2'd0, 4'd4, 0, 1'b0, "b2b", qo, so);
        chk("b2b_q_const", 64'(qo), 64'h00);
        @(negedge clk);
        chk("b2b_done_1cyc", 64'(done), 64'd0);

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            bit gl;
            a = AW'($urandom_range(0, 15));
            gl = (a >= 3) && ($urandom_range(0, 3) == 0);
            do_op(8'($urandom), 2'($urandom), a, -1, gl, "rnd", qo, so);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rnd_done_1cyc", 64'(done), 64'd0);
            end
        end

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        start = 1'b1; load_val = 8'hFF; mode = 2'd2; amount = 4'd8; serial_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_q", 64'(q), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("mid_rst_no_done", 64'(dcnt), 64'd0);

`ifdef SEQ_SHIFT_ABORT_EN
        start = 1'b1; load_val = 8'hF0; mode = 2'd0; amount = 4'd5; serial_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_q", 64'(q), 64'h3C);
        chk("abort_busy", 64'(busy), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
